// File: rtl/fetch_pc_gen.sv
// rtl/fetch_pc_gen.sv - fetch-group PC generator with held branch redirect and I-side exception flags
// Optional feature macro: MANGO_FETCH_ALIGN_EN (fetch groups aligned to 4*FETCH_WIDTH bytes)
module fetch_pc_gen #(
    parameter int                ADDR_W      = 32,
    parameter int                FETCH_WIDTH = 2,
    parameter logic [ADDR_W-1:0] RESET_VEC   = 32'hBFC00000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   flush,
    input  logic [ADDR_W-1:0]      flush_pc,
    input  logic                   br_flag,
    input  logic [ADDR_W-1:0]      br_addr,
    input  logic                   usermode,
    input  logic                   i_tlbr,
    input  logic                   i_tlbi,
    input  logic                   fetch_ack,
    output logic                   fetch_req,
    output logic [ADDR_W-1:0]      pc,
    output logic [ADDR_W-1:0]      pc_seq,
    output logic [FETCH_WIDTH-1:0] valid_mask,
    output logic [2:0]             excp,
    output logic                   i_en
);

    localparam int                GROUP_BYTES = 4 * FETCH_WIDTH;
    localparam int                OFF_W       = $clog2(GROUP_BYTES);
    localparam logic [ADDR_W-1:0] GROUP_INC   = ADDR_W'(GROUP_BYTES);

    logic              pend_v;
    logic [ADDR_W-1:0] pend_addr;
    logic              adv;
    logic              ade;

    assign fetch_req = i_en;
    assign adv       = i_en & fetch_ack & ~stall;

    // A redirect that cannot be taken yet is parked in pend_addr; flush always wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= '0;
            i_en      <= 1'b0;
            pend_v    <= 1'b0;
            pend_addr <= '0;
        end else if (!i_en) begin
            i_en <= 1'b1;
            pc   <= flush ? flush_pc : RESET_VEC;
        end else if (flush) begin
            pc     <= flush_pc;
            pend_v <= 1'b0;
        end else if (br_flag && adv) begin
            pc     <= br_addr;
            pend_v <= 1'b0;
        end else if (br_flag) begin
            pend_v    <= 1'b1;
            pend_addr <= br_addr;
        end else if (adv && pend_v) begin
            pc     <= pend_addr;
            pend_v <= 1'b0;
        end else if (adv) begin
            pc <= pc_seq;
        end
    end

`ifdef MANGO_FETCH_ALIGN_EN
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(GROUP_BYTES - 1);

    assign pc_seq = (pc & ~ALIGN_MASK) + GROUP_INC;

    // Slots below the entry slot of a mid-group target are not part of the fetch.
    generate
        if (FETCH_WIDTH == 1) begin : g_mask_single
            assign valid_mask = i_en;
        end else begin : g_mask_multi
            logic [OFF_W-3:0] slot;
            assign slot = pc[OFF_W-1:2];
            for (genvar k = 0; k < FETCH_WIDTH; k++) begin : g_slot
                assign valid_mask[k] = i_en & (slot <= (OFF_W-2)'(k));
            end
        end
    endgenerate
`else
    assign pc_seq     = pc + GROUP_INC;
    assign valid_mask = {FETCH_WIDTH{i_en}};
`endif

    assign ade  = (pc[1:0] != 2'b00) | (usermode & pc[ADDR_W-1]);
    assign excp = i_en ? {i_tlbi, i_tlbr, ade} : 3'b000;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb/tb_fetch_pc_gen.sv - directed plus randomized checking of fetch_pc_gen against a behavioural model
module tb_fetch_pc_gen;

    localparam int          AW = 32;
    localparam int          FW = 2;
    localparam int          GB = 4 * FW;
    localparam logic [31:0] RV = 32'hBFC00000;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          stall, flush, br_flag, usermode, i_tlbr, i_tlbi, fetch_ack;
    logic [31:0]   flush_pc, br_addr;
    logic          fetch_req, i_en;
    logic [31:0]   pc, pc_seq;
    logic [FW-1:0] valid_mask;
    logic [2:0]    excp;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    fetch_pc_gen #(.ADDR_W(AW), .FETCH_WIDTH(FW), .RESET_VEC(RV)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_pc(flush_pc),
        .br_flag(br_flag), .br_addr(br_addr), .usermode(usermode),
        .i_tlbr(i_tlbr), .i_tlbi(i_tlbi), .fetch_ack(fetch_ack),
        .fetch_req(fetch_req), .pc(pc), .pc_seq(pc_seq), .valid_mask(valid_mask),
        .excp(excp), .i_en(i_en)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference state: architectural pc, boot flag and the single parked redirect.
    logic [31:0] m_pc = '0;
    logic [31:0] m_pa = '0;
    bit          m_en = 1'b0;
    bit          m_pv = 1'b0;
    bit          m_adv;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc = '0; m_en = 1'b0; m_pv = 1'b0; m_pa = '0;
        end else if (!m_en) begin
            m_en = 1'b1;
            m_pc = flush ? flush_pc : RV;
        end else begin
            m_adv = fetch_ack && !stall;
            if (flush) begin
                m_pc = flush_pc; m_pv = 1'b0;
            end else if (br_flag) begin
                if (m_adv) begin
                    m_pc = br_addr; m_pv = 1'b0;
                end else begin
                    m_pv = 1'b1; m_pa = br_addr;
                end
            end else if (m_adv) begin
                if (m_pv) begin
                    m_pc = m_pa; m_pv = 1'b0;
                end else begin
                    m_pc = exp_seq(m_pc);
                end
            end
        end
    end

    function automatic logic [31:0] exp_seq(input logic [31:0] p);
`ifdef MANGO_FETCH_ALIGN_EN
        return 32'((p - (p % GB)) + GB);
`else
        return 32'(p + GB);
`endif
    endfunction

    function automatic logic [FW-1:0] exp_mask(input logic [31:0] p, input bit en);
        logic [FW-1:0] m;
        m = '0;
        for (int k = 0; k < FW; k++) begin
`ifdef MANGO_FETCH_ALIGN_EN
            m[k] = en && (k >= int'((p % GB) / 4));
`else
            m[k] = en;
`endif
        end
        return m;
    endfunction

    function automatic logic [2:0] exp_excp(input logic [31:0] p, input bit en);
        if (!en) return 3'b000;
        return {i_tlbi, i_tlbr, (p % 4 != 0) || (usermode && p >= 32'h8000_0000)};
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("pc", pc, m_pc);
            chk("i_en", i_en, m_en);
            chk("fetch_req", fetch_req, m_en);
            chk("pc_seq", pc_seq, exp_seq(m_pc));
            chk("valid_mask", valid_mask, exp_mask(m_pc, m_en));
            chk("excp", excp, exp_excp(m_pc, m_en));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        stall = 0; flush = 0; br_flag = 0; usermode = 0; i_tlbr = 0; i_tlbi = 0;
        fetch_ack = 1; flush_pc = '0; br_addr = '0;
        #2 rst = 1'b1;
        #1 cmp_en = 1'b1;
        repeat (2) tick;
        chk("reset_pc", pc, 32'h0);
        chk("reset_req", fetch_req, 1'b0);
        chk("reset_mask", valid_mask, '0);
        chk("reset_excp", excp, 3'b000);

        // Boot and sequential run
        rst = 1'b0;
        tick; chk("boot_pc", pc, 32'hBFC00000); chk("boot_en", i_en, 1'b1);
        tick; chk("seq1_pc", pc, 32'hBFC00008);
        tick; chk("seq2_pc", pc, 32'hBFC00010);

        // Branch under stall is held, then applied
        stall = 1; br_flag = 1; br_addr = 32'h80001000;
        tick; chk("stall_hold1", pc, 32'hBFC00010);
        br_flag = 0;
        tick; chk("stall_hold2", pc, 32'hBFC00010);
        stall = 0;
        tick; chk("pend_apply", pc, 32'h80001000);
        tick; chk("pend_seq", pc, 32'h80001008);

        // Flush discards a pending branch
        stall = 1; br_flag = 1; br_addr = 32'h80001000;
        tick; br_flag = 0; flush = 1; flush_pc = 32'hBFC00380;
        tick; chk("flush_pc", pc, 32'hBFC00380); flush = 0;
        tick; chk("flush_hold", pc, 32'hBFC00380); stall = 0;
        tick; chk("flush_drop_pend", pc, 32'hBFC00388);

        // Memory backpressure
        flush = 1; flush_pc = 32'h80000000;
        tick; flush = 0; fetch_ack = 0;
        for (int i = 0; i < 3; i++) begin
            tick; chk("noack_pc", pc, 32'h80000000); chk("noack_req", fetch_req, 1'b1);
        end
        fetch_ack = 1;
        tick; chk("ack_adv", pc, 32'h80000008);

        // Exception flags
        br_flag = 1; br_addr = 32'h80000006;
        tick; br_flag = 0; fetch_ack = 0;
        #1 chk("ade_misalign", excp, 3'b001);
        flush = 1; flush_pc = 32'h80000000;
        tick; flush = 0; usermode = 1;
        #1 chk("ade_user_kseg", excp, 3'b001);
        flush = 1; flush_pc = 32'h00400000;
        tick; flush = 0;
        #1 chk("user_useg_ok", excp, 3'b000);
        i_tlbr = 1;
        #1 chk("tlbr_flag", excp, 3'b010);
        i_tlbr = 0; usermode = 0; fetch_ack = 1;

        // Mid-group branch target
        br_flag = 1; br_addr = 32'h80000004;
        tick; br_flag = 0;
`ifdef MANGO_FETCH_ALIGN_EN
        chk("mid_mask", valid_mask, 2'b10); chk("mid_seq", pc_seq, 32'h80000008);
`else
        chk("mid_mask", valid_mask, 2'b11); chk("mid_seq", pc_seq, 32'h8000000C);
`endif

        // Address wrap
        flush = 1; flush_pc = 32'hFFFFFFF8;
        tick; flush = 0;
        chk("wrap_seq", pc_seq, 32'h0);
        tick; chk("wrap_pc", pc, 32'h0);

        // Asynchronous reset drops a pending redirect
        stall = 1; br_flag = 1; br_addr = 32'h80001000;
        tick; br_flag = 0;
        #2 rst = 1'b1;
        #1 chk("async_rst_pc", pc, 32'h0); chk("async_rst_req", fetch_req, 1'b0);
        tick; rst = 1'b0;
        tick; chk("reboot_pc", pc, 32'hBFC00000);
        tick; chk("reboot_stall", pc, 32'hBFC00000); stall = 0;
        tick; chk("reboot_no_pend", pc, 32'hBFC00008);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 399) == 0) rst = 1'b1;
            stall     = ($urandom_range(0, 9) < 3);
            fetch_ack = ($urandom_range(0, 9) < 7);
            br_flag   = ($urandom_range(0, 19) < 3);
            flush     = ($urandom_range(0, 19) == 0);
            usermode  = ($urandom_range(0, 3) == 0);
            i_tlbr    = ($urandom_range(0, 15) == 0);
            i_tlbi    = ($urandom_range(0, 15) == 0);
            br_addr   = $urandom;
            flush_pc  = $urandom;
            if ($urandom_range(0, 3) != 0) br_addr[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) flush_pc[1:0] = 2'b00;
            if ($urandom_range(0, 15) == 0) flush_pc = 32'hFFFFFFF0 | (flush_pc & 32'hC);
            tick;
        end

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_pc_gen.md
Name: fetch_pc_gen

Overview:
- Next-generation fetch program-counter generator for the MangoMIPS32 front end.
- Produces a fetch-group address of FETCH_WIDTH instructions per request and handshakes with the instruction memory interface (req/ack).
- Holds a branch redirect that arrives while fetch cannot advance, and applies it on the next advance instead of dropping it.
- Raises instruction-side exception flags (AdE, TLB refill, TLB invalid) for the current fetch address.

Parameters:
- ADDR_W, 32, address width; must be ≥ 3 and ≥ log2(4*FETCH_WIDTH)+1.
- FETCH_WIDTH, 2, instructions per fetch group; legal values 1, 2, 4.
- RESET_VEC, 32'hBFC00000, first fetch address after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- stall  in  1  pipeline stall; blocks sequential and branch advance.
- flush  in  1  exception/eret redirect; highest priority.
- flush_pc  in  ADDR_W  flush target.
- br_flag  in  1  branch/jump redirect request.
- br_addr  in  ADDR_W  branch target.
- usermode  in  1  CPU in user mode.
- i_tlbr  in  1  TLB refill miss for the current pc.
- i_tlbi  in  1  TLB invalid for the current pc.
- fetch_ack  in  1  memory accepted the current request.
- fetch_req  out  1  fetch request valid.
- pc  out  ADDR_W  current fetch-group address.
- pc_seq  out  ADDR_W  sequential next address (combinational).
- valid_mask  out  FETCH_WIDTH  per-slot valid bit for the group; bit 0 is the lowest address.
- excp  out  3  {tlbi, tlbr, ade} (bit 0 = ade, bit 1 = tlbr, bit 2 = tlbi).
- i_en  out  1  fetch enabled (low only in the first cycle after reset).

Behaviour:
Reset (asynchronous)
- pc = 0, i_en = 0, pend_v = 0, pend_addr = 0.
- Therefore fetch_req = 0 and valid_mask = 0.

Boot
- First clock edge after reset release: i_en <= 1 and pc <= RESET_VEC, regardless of stall, br_flag and ack.
- If flush is high on that edge, pc <= flush_pc instead.

Definitions
- fetch_req = i_en.
- adv = fetch_req & fetch_ack & ~stall.

Update priority (per clock, i_en = 1)
1. flush: pc <= flush_pc and pend_v <= 0. Ignores stall and ack, and cancels any in-flight fetch.
2. br_flag & adv: pc <= br_addr and pend_v <= 0.
3. br_flag & ~adv: pend_v <= 1 and pend_addr <= br_addr; pc is held. A later br_flag overwrites pend_addr (latest wins).
4. adv & pend_v: pc <= pend_addr and pend_v <= 0.
5. adv: pc <= pc_seq.
6. Otherwise: hold.

Address arithmetic
- pc_seq wraps modulo 2^ADDR_W; there is no overflow flag.
- 0xFFFFFFF8 + 8 yields 0.

Exceptions (combinational on the registered pc)
- excp[0] = (pc[1:0] != 0) | (usermode & pc[ADDR_W-1]).
- excp[1] = i_tlbr; excp[2] = i_tlbi.
- Flags are forced to 0 while i_en = 0.
- excp does not gate fetch_req; the pipeline discards the group and later flushes.

Reset mid-operation
- Reset clears pend_v immediately (asynchronous); pending redirects are lost.

Optional Feature:
MANGO_FETCH_ALIGN_EN

Defined (fetch groups aligned to 4*FETCH_WIDTH bytes):
- pc_seq = (pc & ~(4*FETCH_WIDTH-1)) + 4*FETCH_WIDTH.
- valid_mask bit k = 1 iff k ≥ pc[log2(4*FETCH_WIDTH)-1:2], i.e. slots below the entry slot of a mid-group target are invalid.

Undefined:
- pc_seq = pc + 4*FETCH_WIDTH.
- valid_mask = all ones whenever i_en = 1.

Test Plan:
1. Release reset, hold ack = 1, stall = 0 (FETCH_WIDTH = 2) → cycle 1: pc = 0xBFC00000, i_en = 1; then 0xBFC00008, 0xBFC00010; fetch_req = 0 during reset.
2. At pc = 0xBFC00010 with stall = 1, pulse br_flag, br_addr = 0x80001000 for one cycle; release stall two cycles later → pc holds 0xBFC00010 while stalled, then goes to 0x80001000, then 0x80001008.
3. Pending branch to 0x80001000 and, in the same stall window, flush = 1 with flush_pc = 0xBFC00380 → next cycle pc = 0xBFC00380, pending discarded; after release, pc = 0xBFC00388.
4. ack = 0 for 3 cycles at pc = 0x80000000 → pc held and fetch_req = 1 throughout; on the ack cycle pc → 0x80000008.
5. br_addr = 0x80000006 applied → excp[0] = 1. Separately, usermode = 1 with pc = 0x80000000 → excp[0] = 1; usermode = 1 with pc = 0x00400000 → excp[0] = 0. Drive i_tlbr = 1 → excp[1] = 1.
6. MANGO_FETCH_ALIGN_EN, FETCH_WIDTH = 4, branch to 0x8000000C → valid_mask = 4'b1000, next pc = 0x80000010 with valid_mask = 4'b1111. Without the macro, next pc = 0x8000001C and valid_mask = 4'b1111.
